weight_mem_responder: RTL and testbench
=======================================

Name: weight_mem_responder

Overview:
- On-chip weight SRAM server on the memory side of the weight fetch interface.
- Serves the 18-lane weight read requests (per-lane address in; per-lane data, echoed address and valid out).
- Weights are written through an off-chip load port.
- A single-ported storage array is shared by all lanes. Requests are captured as a batch and served one lane per cycle, lowest index first.

Parameters:
LANES, 18, number of request/response lanes
ADDR_W, 16, lane and load address width
DATA_W, 16, weight word width
DEPTH, 4096, storage words (power of two); index = addr[log2(DEPTH)-1:0]

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
load_en_i  input  1  off-chip write strobe
load_addr_i  input  ADDR_W  write address
load_data_i  input  DATA_W  write data
weight_req_i  input  LANES  per-lane read request
weight_addr_i  input  LANES x ADDR_W  per-lane read address
weight_data_o  output  LANES x DATA_W  per-lane read data
weight_addr_o  output  LANES x ADDR_W  per-lane echoed address of the returned data
weight_valid_o  output  LANES  per-lane data valid (sticky per batch)
busy_o  output  1  batch in service
batch_done_o  output  1  one-cycle pulse, batch complete

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset: FSM=IDLE; pending mask=0; all weight_data_o=0, weight_addr_o=0, weight_valid_o=0; busy_o=0; batch_done_o=0.
- Storage contents are not reset.
- FSM states: IDLE and SERVE.
- IDLE -> SERVE:
  - Occurs at the edge where |weight_req_i=1 and load_en_i=0.
  - At that edge: pending mask <= weight_req_i; all lane addresses are latched; weight_valid_o <= 0.
  - Data/addr outputs of non-requested lanes keep their old values but are not valid.
- busy_o = (state==SERVE), registered.
- Requesters hold req/addr stable until busy_o is seen high. Changes to req/addr while busy_o=1 are ignored (batch semantics).
- SERVE, one service slot per cycle while load_en_i=0:
  - k = lowest set bit of pending.
  - At the clock edge:
    - weight_data_o[k] <= mem[latched_addr[k] mod DEPTH]
    - weight_addr_o[k] <= latched_addr[k]
    - weight_valid_o[k] <= 1
    - pending[k] <= 0
  - A batch of N lanes with no stalls completes N edges after capture.
- Last lane served, i.e. pending has exactly one bit set at the edge: state <= IDLE; batch_done_o <= 1 for one cycle; busy_o <= 0 at the same edge.
- weight_valid_o bits stay high until the next batch capture or reset.
- load_en_i=1, any state: mem[load_addr_i mod DEPTH] <= load_data_i.
  - In SERVE, the write takes the port: no lane is served that cycle (stall) and pending is unchanged.
  - In IDLE, the write blocks capture that cycle; capture occurs on the first cycle with load_en_i=0.
- Read-after-write: a load at edge t followed by a serve of the same address at edge t+1 returns the new data. No same-cycle read/write collision exists by construction.
- Address wrap: addresses >= DEPTH alias modulo DEPTH. weight_addr_o echoes the full unwrapped ADDR_W address.
- Duplicate addresses across lanes are legal; each lane is served separately.
- Reset mid-SERVE immediately returns to IDLE, clears outputs, and drops the batch. No batch_done_o pulse.
- batch_done_o and a new capture never coincide; re-capture is possible at the edge after the done edge.

Test Plan:
1. Reset then load mem[0..17] = 0x1000+i. Issue req=18'h3FFFF with addr[i]=i -> busy_o=1 one cycle after capture; lane i valid at capture edge +(i+1) with data 0x1000+i; batch_done_o pulses at edge +18; back to IDLE.
2. Sparse batch req=lanes {2,7,17}, addrs {5,5,4100} with DEPTH=4096 -> lane 2 valid at +1 with data=mem[5]; lane 7 valid at +2 with data=mem[5]; lane 17 valid at +3 with data=mem[4]; weight_addr_o[17]=4100; done at +3.
3. During a 4-lane batch assert load_en_i for 2 cycles after the first serve, writing mem[addr of lane 3]=0xBEEF -> completion delayed by exactly 2 cycles (done at +6); lane 3 returns 0xBEEF.
4. In IDLE, assert load_en_i and req together for 1 cycle, then req only -> capture is delayed one cycle; batch latency is counted from the actual capture edge.
5. Assert async reset at edge +3 of an 18-lane batch -> all valid/data/busy outputs go 0 immediately with no done pulse. A new 1-lane request after reset completes at +1 with correct data.
6. Back-to-back batches with req held high through done -> second capture at the edge after the done pulse; previous valid bits clear at that capture.

Source files
------------

// File: rtl/weight_mem_responder.sv
// Weight SRAM server: captures a batch of per-lane read requests and returns one
// lane per cycle, lowest lane first, sharing a single-ported array with the load port.
module weight_mem_responder #(
  parameter int LANES  = 18,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en_i,
  input  logic [ADDR_W-1:0]        load_addr_i,
  input  logic [DATA_W-1:0]        load_data_i,
  input  logic [LANES-1:0]         weight_req_i,
  input  logic [LANES*ADDR_W-1:0]  weight_addr_i,
  output logic [LANES*DATA_W-1:0]  weight_data_o,
  output logic [LANES*ADDR_W-1:0]  weight_addr_o,
  output logic [LANES-1:0]         weight_valid_o,
  output logic                     busy_o,
  output logic                     batch_done_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state, state_next;
  logic [LANES-1:0]    pending;
  logic [ADDR_W-1:0]   lat_addr [LANES];
  logic [DATA_W-1:0]   data_q   [LANES];
  logic [ADDR_W-1:0]   addr_q   [LANES];
  logic [DATA_W-1:0]   mem      [DEPTH];
  logic [LANE_W-1:0]   lane;
  logic                last;
  logic                capture;
  logic                serve;

  // Lowest pending lane wins: scan downward so the final hit is the smallest index.
  always_comb begin
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending[i]) lane = LANE_W'(i);
    end
  end

  assign last = (pending & (pending - LANES'(1))) == '0;

  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    serve      = 1'b0;
    case (state)
      IDLE: begin
        if (!load_en_i && |weight_req_i) begin
          capture    = 1'b1;
          state_next = SERVE;
        end
      end
      SERVE: begin
        if (!load_en_i) begin
          serve = 1'b1;
          if (last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state == SERVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending        <= '0;
      weight_valid_o <= '0;
      batch_done_o   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      batch_done_o <= serve && last;
      if (capture) begin
        pending        <= weight_req_i;
        weight_valid_o <= '0;
      end else if (serve) begin
        pending[lane]        <= 1'b0;
        weight_valid_o[lane] <= 1'b1;
        data_q[lane]         <= mem[lat_addr[lane][IDX_W-1:0]];
        addr_q[lane]         <= lat_addr[lane];
      end
    end
  end

  // NOTE: the storage array and the latched addresses carry no reset; addresses
  // are only consumed under a pending bit, and the array is filled by loads.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < LANES; i++) lat_addr[i] <= weight_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  // Load and serve never share a cycle: a load stalls service, so the port is free.
  always_ff @(posedge clk) begin
    if (load_en_i) mem[load_addr_i[IDX_W-1:0]] <= load_data_i;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign weight_data_o[g*DATA_W +: DATA_W] = data_q[g];
    assign weight_addr_o[g*ADDR_W +: ADDR_W] = addr_q[g];
  end

endmodule

// File: tb/tb_weight_mem_responder.sv
// Randomized scoreboard bench for weight_mem_responder: stimulus pushes expected
// lane responses and done cycles; a negedge monitor pops and compares them.
module tb_weight_mem_responder;

  localparam int LANES  = 18;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef struct {
    int                lane;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    load_en = 1'b0;
  logic [ADDR_W-1:0]       load_addr = '0;
  logic [DATA_W-1:0]       load_data = '0;
  logic [LANES-1:0]        req = '0;
  logic [LANES*ADDR_W-1:0] req_addr;
  logic [LANES*DATA_W-1:0] weight_data;
  logic [LANES*ADDR_W-1:0] weight_addr;
  logic [LANES-1:0]        weight_valid;
  logic                    busy;
  logic                    batch_done;

  logic [ADDR_W-1:0] lane_addr [LANES];
  logic [DATA_W-1:0] ref_mem   [DEPTH];
  exp_t              exp_q[$];
  int                done_q[$];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  weight_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .load_en_i     (load_en),
    .load_addr_i   (load_addr),
    .load_data_i   (load_data),
    .weight_req_i  (req),
    .weight_addr_i (req_addr),
    .weight_data_o (weight_data),
    .weight_addr_o (weight_addr),
    .weight_valid_o(weight_valid),
    .busy_o        (busy),
    .batch_done_o  (batch_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    for (int i = 0; i < LANES; i++) req_addr[i*ADDR_W +: ADDR_W] = lane_addr[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a lane whose valid rises must match the oldest expected response.
  logic [LANES-1:0] prev_valid = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int l = 0; l < LANES; l++) begin
        if (weight_valid[l] && !prev_valid[l]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_valid: lane %0d rose at cycle %0d, expected none", l, cyc);
          end else begin
            e = exp_q.pop_front();
            check("lane_order", 32'(l), 32'(e.lane));
            check($sformatf("lane%0d_data", l), 32'(weight_data[l*DATA_W +: DATA_W]), 32'(e.data));
            check($sformatf("lane%0d_addr", l), 32'(weight_addr[l*ADDR_W +: ADDR_W]), 32'(e.addr));
            check($sformatf("lane%0d_cycle", l), 32'(cyc), 32'(e.cyc));
          end
        end
      end
      if (batch_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: pulse at cycle %0d, expected none", cyc);
        end else begin
          check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
      end
    end
    prev_valid = weight_valid;
  end

  // Reference: lanes return in ascending order, one per non-stalled edge after capture.
  task automatic push_batch(input logic [LANES-1:0] mask, input int c, input int stall_pos,
                            input int stall_n, input logic [ADDR_W-1:0] waddr,
                            input logic [DATA_W-1:0] wdata);
    exp_t e;
    int   p = 0;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        e.lane = l;
        e.addr = lane_addr[l];
        e.data = ref_mem[lane_addr[l] % DEPTH];
        e.cyc  = c + p + 1;
        if (stall_n > 0 && p >= stall_pos) begin
          e.cyc += stall_n;
          if (lane_addr[l] % DEPTH == waddr % DEPTH) e.data = wdata;
        end
        exp_q.push_back(e);
        p++;
      end
    end
    done_q.push_back(c + p + ((stall_n > 0 && stall_pos < p) ? stall_n : 0));
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    ref_mem[a % DEPTH] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_batch(input logic [LANES-1:0] mask, input bit pre_block, input int stall_pos,
                           input int stall_n, input logic [ADDR_W-1:0] waddr,
                           input logic [DATA_W-1:0] wdata);
    int c;
    if (pre_block) begin
      req = mask; load_en = 1'b1; load_addr = waddr; load_data = wdata;
      @(negedge clk);
      check("no_capture_during_load", 32'(busy), 32'd0);
      load_en = 1'b0;
      ref_mem[waddr % DEPTH] = wdata;
    end
    c = cyc + 1;
    push_batch(mask, c, stall_pos, pre_block ? 0 : stall_n, waddr, wdata);
    req = mask;
    @(negedge clk);
    check("busy_after_capture", 32'(busy), 32'd1);
    req = '0;
    if (!pre_block && stall_n > 0) begin
      repeat (stall_pos) @(negedge clk);
      load_en = 1'b1; load_addr = waddr; load_data = wdata;
      repeat (stall_n) @(negedge clk);
      load_en = 1'b0;
      ref_mem[waddr % DEPTH] = wdata;
    end
    drain(200);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a        = ADDR_W'($urandom_range(0, 63));
    a[15:12] = 4'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c, c2, n, sp, sn;
    logic [LANES-1:0] mask;
    for (int i = 0; i < LANES; i++) lane_addr[i] = '0;

    #1 reset = 1'b1;
    #2;
    check("reset_valid", 32'(weight_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(batch_done), 32'd0);
    check("reset_data_zero", 32'(weight_data == '0), 32'd1);
    check("reset_addr_zero", 32'(weight_addr == '0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) load_word(ADDR_W'(i), DATA_W'($urandom));
    for (int i = 0; i < LANES; i++) load_word(ADDR_W'(i), DATA_W'(16'h1000 + i));

    // Full batch, identity addresses.
    for (int i = 0; i < LANES; i++) lane_addr[i] = ADDR_W'(i);
    run_batch('1, 1'b0, 0, 0, '0, '0);

    // Sparse batch with duplicate and aliased addresses.
    lane_addr[2] = 16'd5; lane_addr[7] = 16'd5; lane_addr[17] = 16'd4100;
    run_batch(18'h20084, 1'b0, 0, 0, '0, '0);

    // Two-cycle load stall after the first serve, overwriting lane 3's word.
    for (int i = 0; i < 4; i++) lane_addr[i] = ADDR_W'(10 + i);
    run_batch(18'h0000F, 1'b0, 1, 2, 16'd13, 16'hBEEF);

    // Load coinciding with a request in IDLE delays capture by one cycle.
    lane_addr[4] = 16'd40;
    run_batch(18'h00010, 1'b1, 0, 0, 16'd40, 16'h4444);

    // Reset three serves into a full batch: no done, outputs cleared at once.
    for (int i = 0; i < LANES; i++) lane_addr[i] = ADDR_W'(i);
    c = cyc + 1;
    for (int l = 0; l < 3; l++) exp_q.push_back('{l, ADDR_W'(l), ref_mem[l], c + l + 1});
    req = '1;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midbatch_reset_valid", 32'(weight_valid), 32'd0);
    check("midbatch_reset_busy", 32'(busy), 32'd0);
    check("midbatch_reset_data_zero", 32'(weight_data == '0), 32'd1);
    check("midbatch_reset_pending_consumed", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    lane_addr[9] = 16'd9;
    run_batch(18'h00200, 1'b0, 0, 0, '0, '0);

    // Back-to-back batches with requests held through done.
    for (int i = 0; i < LANES; i++) lane_addr[i] = rand_addr();
    mask = 18'h24891;
    n  = $countones(mask);
    c  = cyc + 1;
    c2 = c + n + 1;
    push_batch(mask, c, 0, 0, '0, '0);
    push_batch(mask, c2, 0, 0, '0, '0);
    req = mask;
    while (cyc < c2) @(negedge clk);
    check("recapture_clears_valid", 32'(weight_valid), 32'd0);
    check("recapture_busy", 32'(busy), 32'd1);
    req = '0;
    drain(200);

    // Randomized batches with random stalls, blocked captures and aliasing.
    for (int it = 0; it < 30; it++) begin
      mask = LANES'($urandom);
      if (mask == '0) mask = LANES'(1);
      for (int i = 0; i < LANES; i++) lane_addr[i] = rand_addr();
      n  = $countones(mask);
      sn = 0; sp = 0;
      if ($urandom_range(0, 2) == 0) begin
        sn = int'($urandom_range(1, 3));
        sp = int'($urandom_range(0, n - 1));
      end
      run_batch(mask, (sn == 0) && ($urandom_range(0, 4) == 0), sp, sn,
                rand_addr(), DATA_W'($urandom));
    end

    check("expected_queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
